uart_tx_word: RTL
=================

UART_TX_WORD -- requirements
Module: uart_tx_word

Interface
REQ-001 SHALL have parameter BYTE_GAP, default 0: number of idle bit periods (line high) inserted after each byte's stop bit; legal range 0..15.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-high despite the name.
REQ-004 SHALL have port clken_16bps  input  1  single-cycle enable at 16x bit rate.
REQ-005 SHALL have port s_txd_data  input  32  word to transmit.
REQ-006 SHALL have port s_valid  input  1  word-valid request.
REQ-007 SHALL have port s_ready  output  1  high when a word can be accepted.
REQ-008 SHALL have port txd  output  1  serial line, registered, idle high.
REQ-009 SHALL have port busy  output  1  high from acceptance until word complete.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at word completion.

Function
REQ-011 SHALL accept a word on the clock edge where s_valid and s_ready are both 1, latching s_txd_data into an internal shift register.
REQ-012 SHALL drive s_ready = 1 only in state IDLE, combinationally from state; s_valid outside IDLE SHALL be ignored and the latched word SHALL NOT change.
REQ-013 SHALL transmit the word as four 8N1 frames, byte order [7:0], [15:8], [23:16], [31:24]; bits within a byte LSB first.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, GAP:
- IDLE -> START on acceptance.
- START -> DATA after one bit period.
- DATA -> STOP after 8 bit periods.
- STOP -> GAP if BYTE_GAP > 0, else next byte's START or IDLE.
- GAP -> next byte's START or IDLE after BYTE_GAP bit periods.
REQ-015 SHALL define one bit period as 16 clken_16bps pulses counted by a 4-bit tick counter; the counter advances only on clk edges with clken_16bps = 1, and the bit ends on the pulse where the counter equals 15 (counter then wraps to 0).
REQ-016 SHALL clear the tick counter on entry to START from IDLE; the tick counter SHALL NOT be cleared between bits or bytes.
REQ-017 SHALL drive txd = 0 in START, the current data bit in DATA, and 1 in STOP, GAP and IDLE; txd changes on the clock edge of the state/bit transition. The first change is the edge of acceptance.
REQ-018 SHALL hold all state, counters and txd when clken_16bps = 0. An indefinitely low clken_16bps SHALL freeze the frame.
REQ-019 SHALL track the byte index with a 2-bit counter and the data bit index with a 3-bit counter. After byte index 3 completes STOP (or GAP), the next state SHALL be IDLE.
REQ-020 SHALL assert tx_done for exactly one cycle on the edge entering IDLE from a completed word; s_ready SHALL be 1 in the following cycle.
REQ-021 SHALL drive busy = 1 in every state except IDLE.
REQ-022 SHALL make the total word duration (4 x (10 + BYTE_GAP) x 16) clken_16bps pulses from acceptance to tx_done.
REQ-023 SHALL accept a new word no earlier than the cycle after tx_done; back-to-back words with s_valid held high SHALL be separated by exactly one IDLE cycle.

Reset
REQ-024 SHALL, on any clock edge with rst_n = 1, force state IDLE, txd = 1, busy = 0, tx_done = 0, all counters = 0 and the shift register = 0.
REQ-025 SHALL abort a frame in progress on reset; txd SHALL be 1 on the edge after the reset edge, with no partial byte completed afterwards.
REQ-026 SHALL NOT accept a word when rst_n = 1 and s_valid = 1 in the same cycle.

Verification
REQ-027 SHALL verify single word: BYTE_GAP=0, s_txd_data=32'h44332211 -> line bits per byte (start..stop) 0,1,0,0,0,1,0,0,0,1 for 0x11, then the frames for 0x22, 0x33, 0x44; tx_done after exactly 640 clken pulses.
REQ-028 SHALL verify gap: BYTE_GAP=2, word 32'hFFFFFFFF -> each stop bit followed by 32 pulses of high line; tx_done after 768 pulses.
REQ-029 SHALL verify stall: clken_16bps held 0 for 100 cycles mid-DATA -> txd, state and counters unchanged; the frame resumes intact.
REQ-030 SHALL verify reset mid-frame: rst_n=1 during byte 2 DATA -> txd=1 and busy=0 next cycle; no tx_done pulse is produced.
REQ-031 SHALL verify back-to-back: s_valid held high with words 32'hA5A5A5A5 then 32'h5A5A5A5A -> second accepted one cycle after first tx_done; s_txd_data changes while busy have no effect.
REQ-032 SHALL verify loopback: txd fed to the team's uart_rx with a shared clken_16bps -> m_rxd_data equals the sent word and s_flag pulses once per word.

Source files
------------

// File: rtl/uart_tx_word.sv
// Serialises a 32-bit word as four 8N1 frames, low byte first, LSB first within each byte.
// Bit timing comes from a 16x enable; BYTE_GAP idle bit periods can follow each stop bit.
module uart_tx_word #(
   parameter int BYTE_GAP = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clken_16bps,
   input  logic [31:0] s_txd_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        txd,
   output logic        busy,
   output logic        tx_done,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam bit         HAS_GAP    = (BYTE_GAP > 0);
   localparam int         GAP_LAST_I = HAS_GAP ? BYTE_GAP - 1 : 0;
   localparam logic [3:0] GAP_LAST   = 4'(GAP_LAST_I);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_tick,  w_tick_nxt;
   logic [2:0]  r_bit,   w_bit_nxt;
   logic [1:0]  r_byte,  w_byte_nxt;
   logic [3:0]  r_gap,   w_gap_nxt;
   logic [31:0] r_shift, w_shift_nxt;
   logic        r_txd,   w_txd_nxt;
   logic        r_done,  w_done_nxt;
   logic        w_bit_end;
   logic        w_frame_end;

   assign w_bit_end   = clken_16bps && (r_tick == 4'd15);
   // A frame ends after its stop bit, or after the last gap bit when a gap is configured.
   assign w_frame_end = w_bit_end &&
                        (((r_state == ST_STOP) && !HAS_GAP) ||
                         ((r_state == ST_GAP) && (r_gap == GAP_LAST)));

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_gap_nxt   = r_gap;
      w_shift_nxt = r_shift;
      w_txd_nxt   = r_txd;
      w_done_nxt  = 1'b0;

      if (clken_16bps && (r_state != ST_IDLE)) w_tick_nxt = r_tick + 4'd1;

      case (r_state)
         ST_IDLE: begin
            if (s_valid) begin
               w_state_nxt = ST_START;
               w_tick_nxt  = 4'd0;
               w_bit_nxt   = 3'd0;
               w_byte_nxt  = 2'd0;
               w_gap_nxt   = 4'd0;
               w_shift_nxt = s_txd_data;
               w_txd_nxt   = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_nxt = ST_DATA;
               w_bit_nxt   = 3'd0;
               w_txd_nxt   = r_shift[0];
            end
         end
         ST_DATA: begin
            // The register shifts once per data bit, so the next byte lands in [7:0].
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = ST_STOP;
                  w_txd_nxt   = 1'b1;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
                  w_txd_nxt = r_shift[1];
               end
            end
         end
         ST_STOP, ST_GAP: begin
            if (w_frame_end) begin
               if (r_byte == 2'd3) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
                  w_txd_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_START;
                  w_byte_nxt  = r_byte + 2'd1;
                  w_txd_nxt   = 1'b0;
               end
            end else if (w_bit_end) begin
               if (r_state == ST_STOP) begin
                  w_state_nxt = ST_GAP;
                  w_gap_nxt   = 4'd0;
               end else begin
                  w_gap_nxt = r_gap + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= ST_IDLE;
         r_tick  <= 4'd0;
         r_bit   <= 3'd0;
         r_byte  <= 2'd0;
         r_gap   <= 4'd0;
         r_shift <= 32'd0;
         r_txd   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
         r_gap   <= w_gap_nxt;
         r_shift <= w_shift_nxt;
         r_txd   <= w_txd_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign s_ready     = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign txd         = r_txd;
   assign tx_done     = r_done;
   assign o_dbg_state = r_state;

endmodule
